// File: rtl/miner_avalon_slave.sv
// Avalon-MM register slave for the miner: assembles message/target words for the
// hashing core, issues load/start/abort strobes and holds the first result found.
module miner_avalon_slave #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slaveAddr,
  input  logic [DATA_W-1:0] slaveWriteData,
  input  logic              slaveWrite,
  input  logic              slaveRead,
  input  logic              slaveChipSelect,
  output logic [DATA_W-1:0] slaveReadData,
  output logic [407:0]      msgOut,
  output logic [255:0]      targetOut,
  output logic              newTarget,
  output logic              newMsg,
  output logic              abortOut,
  input  logic              coreBusy,
  input  logic              validBTC,
  input  logic [31:0]       coreNonce,
  input  logic [255:0]      coreHash,
  output logic [1:0]        fsm_state
);

  // Bus handshake: a write or read takes effect on the rising edge where chip
  // select and the strobe are both high; no wait states, read data is registered
  // and appears the cycle after the read strobe, holding until the next read.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2} state_t;

  state_t            state, state_next;
  logic              seen_busy, seen_busy_next;
  logic              wait_cnt, wait_cnt_next;
  logic [407:0]      msg_q;
  logic [255:0]      tgt_q, hash_q;
  logic [31:0]       nonce_q, status;
  logic              found, err, tgt_loaded, new_target_q, abort_q;
  logic [DATA_W-1:0] rdata_q, rdata_next;
  logic              wr, rd, ctrl_wr, msg_wr, tgt_wr;
  logic              ld_req, start_req, abort_req, clear_req;
  logic              ld_ok, start_ok, err_set, capture;

  assign wr        = slaveChipSelect & slaveWrite;
  assign rd        = slaveChipSelect & slaveRead;
  assign ctrl_wr   = wr && (slaveAddr == ADDR_W'(0));
  assign msg_wr    = wr && (slaveAddr >= ADDR_W'(3)) && (slaveAddr <= ADDR_W'(15));
  assign tgt_wr    = wr && (slaveAddr >= ADDR_W'(16)) && (slaveAddr <= ADDR_W'(23));
  assign ld_req    = ctrl_wr & slaveWriteData[0];
  assign start_req = ctrl_wr & slaveWriteData[1];
  assign abort_req = ctrl_wr & slaveWriteData[2];
  assign clear_req = ctrl_wr & slaveWriteData[3];

  assign ld_ok    = ld_req & ~coreBusy;
  assign start_ok = start_req & ~abort_req & ~coreBusy & tgt_loaded & (state == S_IDLE);
  assign err_set  = (coreBusy & (msg_wr | tgt_wr)) | (ld_req & ~ld_ok) | (start_req & ~start_ok);
  // A clear in the same cycle as a new result must not lose that result.
  assign capture  = validBTC & (~found | clear_req);
  assign status   = {27'b0, err, tgt_loaded, found, coreBusy, state != S_IDLE};

  always_comb begin
    rdata_next = '0;
    if (slaveAddr <= ADDR_W'(1)) rdata_next = DATA_W'(status);
    else if (slaveAddr == ADDR_W'(2)) rdata_next = DATA_W'(nonce_q);
    else if (slaveAddr == ADDR_W'(3)) rdata_next = DATA_W'({msg_q[23:0], 8'h00});
    for (int i = 0; i < 12; i++)
      if (slaveAddr == ADDR_W'(i + 4)) rdata_next = DATA_W'(msg_q[i*32+24 +: 32]);
    for (int i = 0; i < 8; i++) begin
      if (slaveAddr == ADDR_W'(i + 16)) rdata_next = DATA_W'(tgt_q[i*32 +: 32]);
      if (slaveAddr == ADDR_W'(i + 24)) rdata_next = DATA_W'(hash_q[i*32 +: 32]);
    end
  end

  // RUN waits for coreBusy to rise then fall; if it never rises within two
  // cycles after the start pulse, the core missed it and we return to IDLE.
  always_comb begin
    state_next     = state;
    seen_busy_next = seen_busy;
    wait_cnt_next  = wait_cnt;
    if (abort_req) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          state_next     = S_ARMED;
          seen_busy_next = 1'b0;
          wait_cnt_next  = 1'b0;
        end
        S_ARMED: begin
          state_next = S_RUN;
          if (coreBusy) seen_busy_next = 1'b1;
        end
        S_RUN: begin
          if (coreBusy) seen_busy_next = 1'b1;
          else if (seen_busy || wait_cnt) state_next = S_IDLE;
          else wait_cnt_next = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      seen_busy <= 1'b0;
      wait_cnt  <= 1'b0;
    end else begin
      state     <= state_next;
      seen_busy <= seen_busy_next;
      wait_cnt  <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q        <= '0;
      tgt_q        <= '0;
      hash_q       <= '0;
      nonce_q      <= '0;
      found        <= 1'b0;
      err          <= 1'b0;
      tgt_loaded   <= 1'b0;
      new_target_q <= 1'b0;
      abort_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (msg_wr && !coreBusy) begin
        if (slaveAddr == ADDR_W'(3)) msg_q[23:0] <= slaveWriteData[31:8];
        for (int i = 0; i < 12; i++)
          if (slaveAddr == ADDR_W'(i + 4)) msg_q[i*32+24 +: 32] <= slaveWriteData[31:0];
      end
      if (tgt_wr && !coreBusy) begin
        for (int i = 0; i < 8; i++)
          if (slaveAddr == ADDR_W'(i + 16)) tgt_q[i*32 +: 32] <= slaveWriteData[31:0];
      end
      new_target_q <= ld_ok;
      abort_q      <= abort_req;
      if (ld_ok) tgt_loaded <= 1'b1;
      err <= (err & ~clear_req) | err_set;
      if (capture) begin
        found   <= 1'b1;
        nonce_q <= coreNonce;
        hash_q  <= coreHash;
      end else if (clear_req || start_ok) begin
        found <= 1'b0;
      end
      if (rd) rdata_q <= rdata_next;
    end
  end

  // Strobes are gated by reset so a reset drops them in the same cycle.
  assign newTarget     = new_target_q & ~rst;
  assign abortOut      = abort_q & ~rst;
  assign newMsg        = (state == S_ARMED) & ~rst;
  assign slaveReadData = rdata_q;
  assign msgOut        = msg_q;
  assign targetOut     = tgt_q;
  assign fsm_state     = state;

endmodule
